// File: rtl/user_entry.sv
// user_entry: assembles a DIGITS-digit hex guess from switch/strobe inputs
// and presents it to the game controller through a valid/ack handshake.
// Optional inactivity timeout enabled by defining USER_ENTRY_TIMEOUT_EN.
module user_entry #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            digit_stb,
    input  logic                            back_stb,
    input  logic                            submit_stb,
    input  logic                            entry_ack,
    output logic [DIGITS*DIGIT_W-1:0]       userInt,
    output logic [$clog2(DIGITS+1)-1:0]     digit_count,
    output logic                            busy,
    output logic                            entry_valid,
    output logic                            timed_out
);

    localparam int unsigned W  = DIGITS * DIGIT_W;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_HOLD
    } state_t;

    state_t         r_state, w_state_next;
    logic [W-1:0]   r_user, w_user_next;
    logic [CW-1:0]  r_count, w_count_next;
    logic           r_timed_out, w_timed_out_next;
    logic           r_busy, r_valid;

`ifdef USER_ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0]  r_timer, w_timer_next;
`else
    logic           w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and datapath decisions; one accepted action per cycle
    always_comb begin
        w_state_next     = r_state;
        w_user_next      = r_user;
        w_count_next     = r_count;
        w_timed_out_next = r_timed_out;
`ifdef USER_ENTRY_TIMEOUT_EN
        w_timer_next     = r_timer;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next     = ST_ENTER;
                    w_user_next      = '0;
                    w_count_next     = '0;
                    w_timed_out_next = 1'b0;
`ifdef USER_ENTRY_TIMEOUT_EN
                    w_timer_next     = '0;
`endif
                end
            end
            ST_ENTER: begin
                // Ignored strobes (submit short, back at zero, digit at full)
                // fall through so a lower-priority strobe can still act.
                if (submit_stb && (r_count == FULL)) begin
                    w_state_next = ST_HOLD;
                end else if (start) begin
                    w_user_next      = '0;
                    w_count_next     = '0;
                    w_timed_out_next = 1'b0;
`ifdef USER_ENTRY_TIMEOUT_EN
                    w_timer_next     = '0;
`endif
                end else if (back_stb && (r_count != '0)) begin
                    w_user_next  = r_user >> DIGIT_W;
                    w_count_next = r_count - CW'(1);
`ifdef USER_ENTRY_TIMEOUT_EN
                    w_timer_next = '0;
`endif
                end else if (digit_stb && (r_count != FULL)) begin
                    w_user_next  = {r_user[W-DIGIT_W-1:0], digit_in};
                    w_count_next = r_count + CW'(1);
`ifdef USER_ENTRY_TIMEOUT_EN
                    w_timer_next = '0;
`endif
                end
`ifdef USER_ENTRY_TIMEOUT_EN
                else if (r_timer == TO_VAL) begin
                    w_state_next     = ST_HOLD;
                    w_timed_out_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
`endif
            end
            ST_HOLD: begin
                if (entry_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_user      <= '0;
            r_count     <= '0;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_user      <= w_user_next;
            r_count     <= w_count_next;
            r_timed_out <= w_timed_out_next;
            r_busy      <= (w_state_next == ST_ENTER);
            r_valid     <= (w_state_next == ST_HOLD);
        end
    end

`ifdef USER_ENTRY_TIMEOUT_EN
    // Inactivity counter for forced submit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_next;
        end
    end
`endif

    assign userInt     = r_user;
    assign digit_count = r_count;
    assign busy        = r_busy;
    assign entry_valid = r_valid;
    assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_user_entry.sv
// Directed self-checking bench for user_entry.
module tb_user_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  digit_in;
    logic        digit_stb;
    logic        back_stb;
    logic        submit_stb;
    logic        entry_ack;
    logic [15:0] userInt;
    logic [2:0]  digit_count;
    logic        busy;
    logic        entry_valid;
    logic        timed_out;

    int n_checks = 0;
    int n_fail   = 0;

    user_entry #(
        .DIGITS(4),
        .DIGIT_W(4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .digit_in(digit_in),
        .digit_stb(digit_stb),
        .back_stb(back_stb),
        .submit_stb(submit_stb),
        .entry_ack(entry_ack),
        .userInt(userInt),
        .digit_count(digit_count),
        .busy(busy),
        .entry_valid(entry_valid),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_digit(input logic [3:0] d);
        digit_in = d; digit_stb = 1'b1; tick(); digit_stb = 1'b0;
    endtask

    task automatic do_back();
        back_stb = 1'b1; tick(); back_stb = 1'b0;
    endtask

    task automatic do_submit();
        submit_stb = 1'b1; tick(); submit_stb = 1'b0;
    endtask

    task automatic do_ack();
        entry_ack = 1'b1; tick(); entry_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(2); rst = 1'b0;
        n_checks++; if (userInt !== 16'h0000) begin n_fail++; $display("FAIL reset_userInt got %h expected %h", userInt, 16'h0000); end
        n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", digit_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", entry_valid); end
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL reset_timed_out got %b expected 0", timed_out); end
        // strobes in IDLE are ignored
        do_digit(4'h5);
        n_checks++; if (digit_count !== 3'd0 || userInt !== 16'h0000) begin n_fail++; $display("FAIL idle_digit_ignored got %0d/%h expected 0/0000", digit_count, userInt); end
    endtask

    task automatic test_basic_entry();
        do_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b expected 1", busy); end
        do_digit(4'h1); do_digit(4'h2); do_digit(4'h3); do_digit(4'h4);
        n_checks++; if (userInt !== 16'h1234) begin n_fail++; $display("FAIL basic_userInt got %h expected 1234", userInt); end
        n_checks++; if (digit_count !== 3'd4) begin n_fail++; $display("FAIL basic_count got %0d expected 4", digit_count); end
        n_checks++; if (entry_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pre got %b expected 0", entry_valid); end
        do_submit();
        n_checks++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL submit_valid got %b expected 1", entry_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL submit_busy got %b expected 0", busy); end
        idle(3);
        n_checks++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL valid_held got %b expected 1", entry_valid); end
        do_ack();
        n_checks++; if (entry_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ack_idle got valid=%b busy=%b expected 0/0", entry_valid, busy); end
        n_checks++; if (userInt !== 16'h1234) begin n_fail++; $display("FAIL ack_retain got %h expected 1234", userInt); end
    endtask

    task automatic test_hold_ignores();
        do_start();
        do_digit(4'h1); do_digit(4'h2); do_digit(4'h3); do_digit(4'h4);
        do_submit();
        start = 1'b1; digit_in = 4'hF; digit_stb = 1'b1; back_stb = 1'b1;
        tick();
        start = 1'b0; digit_stb = 1'b0; back_stb = 1'b0;
        n_checks++; if (userInt !== 16'h1234) begin n_fail++; $display("FAIL hold_userInt got %h expected 1234", userInt); end
        n_checks++; if (entry_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_state got valid=%b busy=%b expected 1/0", entry_valid, busy); end
        do_ack();
        idle(2);
        n_checks++; if (userInt !== 16'h1234) begin n_fail++; $display("FAIL idle_retain got %h expected 1234", userInt); end
        do_start();
        n_checks++; if (userInt !== 16'h0000 || digit_count !== 3'd0) begin n_fail++; $display("FAIL start_clear got %h/%0d expected 0000/0", userInt, digit_count); end
    endtask

    task automatic test_backspace();
        do_digit(4'hA); do_digit(4'hB); do_digit(4'hC);
        do_back();
        n_checks++; if (userInt !== 16'h00AB || digit_count !== 3'd2) begin n_fail++; $display("FAIL back_shift got %h/%0d expected 00ab/2", userInt, digit_count); end
        do_digit(4'h5); do_digit(4'h6);
        do_submit();
        n_checks++; if (userInt !== 16'hAB56) begin n_fail++; $display("FAIL back_result got %h expected ab56", userInt); end
        n_checks++; if (entry_valid !== 1'b1) begin n_fail++; $display("FAIL back_valid got %b expected 1", entry_valid); end
        do_ack();
    endtask

    task automatic test_boundaries();
        do_start();
        do_back();
        n_checks++; if (userInt !== 16'h0000 || digit_count !== 3'd0) begin n_fail++; $display("FAIL back_empty got %h/%0d expected 0000/0", userInt, digit_count); end
        do_digit(4'h1); do_digit(4'h2); do_digit(4'h3);
        do_submit();
        n_checks++; if (entry_valid !== 1'b0 || busy !== 1'b1 || digit_count !== 3'd3) begin n_fail++; $display("FAIL short_submit got valid=%b busy=%b cnt=%0d expected 0/1/3", entry_valid, busy, digit_count); end
        do_digit(4'h4); do_digit(4'hF);
        n_checks++; if (userInt !== 16'h1234 || digit_count !== 3'd4) begin n_fail++; $display("FAIL fifth_digit got %h/%0d expected 1234/4", userInt, digit_count); end
        // submit beats back in the same cycle
        submit_stb = 1'b1; back_stb = 1'b1; tick(); submit_stb = 1'b0; back_stb = 1'b0;
        n_checks++; if (entry_valid !== 1'b1 || userInt !== 16'h1234) begin n_fail++; $display("FAIL submit_over_back got valid=%b %h expected 1/1234", entry_valid, userInt); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (userInt !== 16'h0 || digit_count !== 3'd0 || busy !== 1'b0 || entry_valid !== 1'b0 || timed_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_hold got %h/%0d/%b/%b/%b expected 0000/0/0/0/0", userInt, digit_count, busy, entry_valid, timed_out);
        end
    endtask

    task automatic test_restart();
        do_start();
        do_digit(4'h9); do_digit(4'h8);
        do_ack();
        n_checks++; if (busy !== 1'b1 || entry_valid !== 1'b0 || userInt !== 16'h0098) begin n_fail++; $display("FAIL ack_in_enter got busy=%b valid=%b %h expected 1/0/0098", busy, entry_valid, userInt); end
        do_start();
        n_checks++; if (userInt !== 16'h0000 || digit_count !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got %h/%0d/%b expected 0000/0/1", userInt, digit_count, busy); end
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_timeout();
        do_start();
        do_digit(4'h7);
        idle(10);
        n_checks++; if (busy !== 1'b1 || entry_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early got busy=%b valid=%b expected 1/0", busy, entry_valid); end
        idle(15);
`ifdef USER_ENTRY_TIMEOUT_EN
        n_checks++; if (entry_valid !== 1'b1 || timed_out !== 1'b1 || userInt !== 16'h0007) begin n_fail++; $display("FAIL timeout_fire got valid=%b to=%b %h expected 1/1/0007", entry_valid, timed_out, userInt); end
        do_ack();
        do_start();
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b expected 0", timed_out); end
`else
        n_checks++; if (entry_valid !== 1'b0 || busy !== 1'b1 || timed_out !== 1'b0 || userInt !== 16'h0007) begin n_fail++; $display("FAIL no_timeout got valid=%b busy=%b to=%b %h expected 0/1/0/0007", entry_valid, busy, timed_out, userInt); end
`endif
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; digit_in = 4'h0; digit_stb = 1'b0;
        back_stb = 1'b0; submit_stb = 1'b0; entry_ack = 1'b0;
        #1;
        test_reset();
        test_basic_entry();
        test_hold_ignores();
        test_backspace();
        test_boundaries();
        test_restart();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_entry.md
# user_entry

Collects the player's guess one hex digit at a time from the board switches and a debounced "enter digit" button, assembling the 16-bit `userInt` word that the accuracy checker compares against `randInt`. Sits between the button/switch front end and the game controller. Presents the finished guess through a valid/ack handshake and supports digit deletion and an optional inactivity timeout.

## Interface
- `DIGITS`, 4, number of digits in a guess
- `DIGIT_W`, 4, bits per digit; `userInt` width is `DIGITS*DIGIT_W`
- `TIMEOUT_CYCLES`, 100_000_000, idle cycles in ENTER before forced submit (used only with `USER_ENTRY_TIMEOUT_EN`)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse: begin a new entry round
- `digit_in`  in  DIGIT_W  switch value sampled on `digit_stb`
- `digit_stb`  in  1  one-cycle pulse: append `digit_in`
- `back_stb`  in  1  one-cycle pulse: delete last digit
- `submit_stb`  in  1  one-cycle pulse: submit guess
- `entry_ack`  in  1  game controller has consumed the guess
- `userInt`  out  DIGITS*DIGIT_W  assembled guess, registered
- `digit_count`  out  $clog2(DIGITS+1)  digits currently entered
- `busy`  out  1  high in ENTER
- `entry_valid`  out  1  guess ready, held until acked
- `timed_out`  out  1  current guess was forced by timeout

## Operation
- States: IDLE, ENTER, HOLD.
- IDLE: strobes ignored. `start` -> ENTER, clear `userInt`, `digit_count`, `timed_out`, timer.
- ENTER, one action per cycle, priority `submit_stb` > `back_stb` > `digit_stb`:
  - `digit_stb` with count < DIGITS: `userInt <= {userInt[W-DIGIT_W-1:0], digit_in}`, count+1. With count == DIGITS: ignored.
  - `back_stb` with count > 0: `userInt <= userInt >> DIGIT_W` (zero-fill), count-1. With count == 0: ignored.
  - `submit_stb` with count == DIGITS: -> HOLD. With count < DIGITS: ignored, stay in ENTER.
  - `start` in ENTER (no submit that cycle): restart, clears as from IDLE. `submit_stb` beats `start`.
- HOLD: `entry_valid` = 1, `userInt` frozen; all strobes and `start` ignored. `entry_ack` sampled high -> IDLE; `userInt` keeps its value until the next `start`.
- First digit entered ends up most significant: entering 1,2,3,4 yields 0x1234.

## Timing
- Reset values: state IDLE, `userInt` 0, `digit_count` 0, `busy` 0, `entry_valid` 0, `timed_out` 0.
- `rst` overrides everything in any state, including mid-entry and HOLD; outputs at reset values the cycle after.
- All outputs registered; a strobe at edge N is reflected at edge N+1.
- Submit latency: `submit_stb` at edge N -> `entry_valid` high after edge N (state HOLD), 1 cycle.
- `entry_valid` drops the cycle after the edge that samples `entry_ack`=1. `entry_ack` while not in HOLD is ignored.
- `digit_stb` is a pulse; a strobe held high N cycles appends N digits, so the front end must debounce and edge-detect.

## Configuration
- `USER_ENTRY_TIMEOUT_EN` defined: a cycle counter runs in ENTER and clears on `start` and on any accepted digit or back action. When it reaches `TIMEOUT_CYCLES`, the block goes to HOLD with `timed_out` = 1 and `userInt` as is (partial, zero-padded low digits unshifted). The transition takes one cycle. `timed_out` clears on `start` or `rst`.
- Not defined: no counter is synthesized, `timed_out` is tied 0, and ENTER waits indefinitely.

## Test plan
- Reset, `start`, digits 0x1,0x2,0x3,0x4, `submit_stb` -> `userInt`=0x1234, `digit_count`=4, `entry_valid` high 1 cycle after submit until `entry_ack`, then IDLE.
- Digits A,B,C, `back_stb`, digits 5,6, submit -> `userInt`=0xAB56.
- Submit with 3 digits -> ignored, `entry_valid` stays 0. 5th digit 0xF after 0x1234 -> `userInt` stays 0x1234.
- Same-cycle `submit_stb`+`back_stb` with 4 digits -> HOLD, `userInt` unchanged. `rst` asserted during HOLD -> all outputs 0 next cycle.
- HOLD: `start` and `digit_stb` ignored, `userInt` stable. After ack, `userInt` retains 0x1234 until the next `start` clears it to 0.
- With `USER_ENTRY_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20: enter 0x7, idle 20 cycles -> `entry_valid`=1, `timed_out`=1, `userInt`=0x0007. Without the macro, the same stimulus stays in ENTER with `timed_out`=0.
